// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and sticky error flags.
// The rx pad is double-synchronised; every receive decision uses the second stage only.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [7:0]            data_out,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  framing_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

  localparam logic [15:0]           HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]           FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic                  rx_meta_q, rxs_q;
  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  push_q, push_d;
  logic                  ferr_set;
  logic                  ovr_set;
  logic                  overrun_q, overrun_d;
  logic                  framing_q, framing_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full, empty, do_push, do_pop;
  logic [7:0]            mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      overrun_q <= overrun_d;
      framing_q <= framing_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Counter is held at zero in IDLE/BREAK so it is always zero on entry to a timed state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    do_pop    = rd & ~empty;
    do_push   = push_q & (~full | do_pop);
    ovr_set   = push_q & full & ~rd;
    wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    overrun_d = ovr_set  | (overrun_q & ~clr_err);
    framing_d = ferr_set | (framing_q & ~clr_err);
  end

  // shift_q is stable through IDLE, so it still holds the byte during the push strobe.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign valid       = ~empty;
  assign data_out    = empty ? 8'h00 : mem[rd_ptr_q];
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign framing_err = framing_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a small-period, depth-4 instance for function
// and a default-parameter instance for bit-period skew tolerance.
module tb_uart_rx_fifo;

  localparam int CPB    = 16;
  localparam int DL     = 2;
  localparam int RD_HIT = 3 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          rst, rx, rd, clr_err;
  logic [7:0]    data_out;
  logic          valid, overrun, framing_err;
  logic [DL:0]   count;
  logic          rx2, rd2;
  logic [7:0]    data_out2;
  logic          valid2, overrun2, framing_err2;
  logic [4:0]    count2;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic [7:0] sb2[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(rst), .rx(rx), .rd(rd), .clr_err(clr_err),
    .data_out(data_out), .valid(valid), .count(count),
    .overrun(overrun), .framing_err(framing_err)
  );

  uart_rx_fifo u_def (
    .clk(clk), .reset(rst), .rx(rx2), .rd(rd2), .clr_err(1'b0),
    .data_out(data_out2), .valid(valid2), .count(count2),
    .overrun(overrun2), .framing_err(framing_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting right after a clock edge; rd pulses on cycle rd_at (instance 0).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period,
                            input bit sel, input int rd_at);
    logic [9:0] bits;
    logic [7:0] exp;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * period; i++) begin
      if (sel) rx2 = bits[i / period];
      else     rx  = bits[i / period];
      if (!sel) begin
        if (i == rd_at) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL coincident_pop: scoreboard empty, data_out=%h", data_out);
          end else begin
            exp = sb.pop_front();
            if (data_out !== exp) begin
              failures++;
              $display("FAIL coincident_pop: data_out=%h expected %h", data_out, exp);
            end
          end
          rd = 1'b1;
        end else begin
          rd = 1'b0;
        end
      end
      tick();
    end
    rd = 1'b0;
  endtask

  task automatic pop_byte();
    logic [7:0] exp;
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL pop_valid: valid=%b expected 1", valid);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL pop_data: scoreboard empty, data_out=%h", data_out);
    end else begin
      exp = sb.pop_front();
      if (data_out !== exp) begin
        failures++;
        $display("FAIL pop_data: data_out=%h expected %h", data_out, exp);
      end else begin
        $display("pop %h ok", data_out);
      end
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0; rx2 = 1'b1; rd2 = 1'b0;
    repeat (3) tick();
    checks++;
    if ({data_out, valid, count, overrun, framing_err} !== '0) begin
      failures++;
      $display("FAIL reset_state: d=%h v=%b c=%0d o=%b f=%b expected all 0",
               data_out, valid, count, overrun, framing_err);
    end
    rst = 1'b0;
    repeat (4) tick();
    rx = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    checks++;
    if ({data_out, valid, count, overrun, framing_err} !== '0) begin
      failures++;
      $display("FAIL reset_midframe: d=%h v=%b c=%0d o=%b f=%b expected all 0",
               data_out, valid, count, overrun, framing_err);
    end
    rst = 1'b0;
    repeat (20) tick();
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1, CPB, 1'b0, -1);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h55 || count !== 3'd1) begin
      failures++;
      $display("FAIL after_reset_rx: v=%b d=%h c=%0d expected 1 55 1", valid, data_out, count);
    end
    pop_byte();
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL after_reset_pop: count=%0d expected 0", count);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (30) tick();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || framing_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch: v=%b c=%0d f=%b expected 0 0 0", valid, count, framing_err);
    end
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, CPB, 1'b0, -1);
    checks++;
    if (count !== 3'd1) begin
      failures++;
      $display("FAIL glitch_recover: count=%0d expected 1", count);
    end
    pop_byte();
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5];
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1, CPB, 1'b0, -1);
    end
    checks++;
    if (count !== 3'd4 || overrun !== 1'b1 || framing_err !== 1'b0) begin
      failures++;
      $display("FAIL overrun: c=%0d o=%b f=%b expected 4 1 0", count, overrun, framing_err);
    end
    for (int i = 0; i < 4; i++) pop_byte();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL drained: v=%b c=%0d expected 0 0", valid, count);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL rd_empty: v=%b c=%0d o=%b expected 0 0 1", valid, count, overrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_full_rd();
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1, CPB, 1'b0, -1);
    end
    checks++;
    if (count !== 3'd4) begin
      failures++;
      $display("FAIL fill: count=%0d expected 4", count);
    end
    sb.push_back(8'h66);
    send_frame(8'h66, 1'b1, CPB, 1'b0, RD_HIT);
    checks++;
    if (count !== 3'd4 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL full_push_rd: c=%0d o=%b expected 4 0", count, overrun);
    end
    for (int i = 0; i < 4; i++) pop_byte();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL wrap_drain: v=%b c=%0d expected 0 0", valid, count);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h12, 1'b0, CPB, 1'b0, -1);
    repeat (100) tick();
    checks++;
    if (framing_err !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL framing: f=%b c=%0d expected 1 0", framing_err, count);
    end
    rx = 1'b1;
    repeat (CPB) tick();
    sb.push_back(8'h34);
    send_frame(8'h34, 1'b1, CPB, 1'b0, -1);
    checks++;
    if (count !== 3'd1 || framing_err !== 1'b1) begin
      failures++;
      $display("FAIL after_break: c=%0d f=%b expected 1 1", count, framing_err);
    end
    pop_byte();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (framing_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: f=%b o=%b expected 0 0", framing_err, overrun);
    end
  endtask

  task automatic test_skew();
    int periods [2];
    logic [7:0] exp;
    periods = '{447, 421};
    for (int p = 0; p < 2; p++) begin
      sb2.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, periods[p], 1'b1, -1);
      repeat (20) tick();
      exp = sb2.pop_front();
      checks++;
      if (valid2 !== 1'b1 || data_out2 !== exp || framing_err2 !== 1'b0) begin
        failures++;
        $display("FAIL skew_%0d: v=%b d=%h f=%b expected 1 %h 0",
                 periods[p], valid2, data_out2, framing_err2, exp);
      end else begin
        $display("skew period %0d byte %h ok", periods[p], data_out2);
      end
      rd2 = 1'b1;
      tick();
      rd2 = 1'b0;
      checks++;
      if (count2 !== 5'd0) begin
        failures++;
        $display("FAIL skew_pop_%0d: count=%0d expected 0", periods[p], count2);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_glitch();
    test_overrun();
    test_full_rd();
    test_framing();
    test_skew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
